// File: rtl/uart.sv
// 8051-style serial port: mode 0 shift register, modes 1-3 async, auto-reload baud timer.
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling on async receive.
module uart (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] AB,
  inout  wire  [7:0] DB,
  input  logic       rd,
  input  logic       wr,
  output logic       TxD,
  inout  wire        RxD,
  output logic       Intuart
);

  localparam logic [7:0] A_TL   = 8'h96;
  localparam logic [7:0] A_TH   = 8'h97;
  localparam logic [7:0] A_SBUF = 8'h98;
  localparam logic [7:0] A_SCON = 8'h99;

  typedef enum logic [1:0] {
    M0_IDLE, M0_WAIT, M0_LOW, M0_HIGH
  } m0_state_t;

  logic [7:0]  scon, scon_nx, th, tl, rx_sbuf;
  logic [15:0] cnt;
  logic [1:0]  sm;
  logic        tick, rxd_in;
  logic        we_scon, we_sbuf, we_th, we_tl;
  logic        db_oe;
  logic [7:0]  db_out;

  m0_state_t   m0_st, m0_nx;
  logic        m0_rx, m0_last, m0_done;
  logic        m0_tx_go, m0_rx_go;
  logic [7:0]  m0_sh;
  logic [3:0]  m0_cnt;

  logic        tx_busy, tx_go, tx_done;
  logic [10:0] tx_sh;
  logic [3:0]  tx_tc, tx_bc, tx_last;

  logic        rx_busy, rx_go, rx_prev, rx_m1, rx_b9;
  logic        rx_eval, rx_fin, rx_accept, rx_bit, rx_nine;
  logic        rx_s1;
  logic [3:0]  rx_tc, rx_bc;
  logic [7:0]  rx_data;
`ifdef UART_RX_MAJORITY_EN
  logic        rx_s0;
`endif

  assign sm      = scon[7:6];
  assign tick    = (cnt == 16'hFFFF);
  assign rxd_in  = RxD;
  assign Intuart = scon[1] | scon[0];

  assign we_scon = !wr && (AB == A_SCON);
  assign we_sbuf = !wr && (AB == A_SBUF);
  assign we_th   = !wr && (AB == A_TH);
  assign we_tl   = !wr && (AB == A_TL);

  always_comb begin
    db_oe  = !rd;
    db_out = 8'h00;
    unique case (AB)
      A_SCON:  db_out = scon;
      A_SBUF:  db_out = rx_sbuf;
      A_TH:    db_out = th;
      A_TL:    db_out = tl;
      default: db_oe  = 1'b0;
    endcase
  end

  assign DB = db_oe ? db_out : 8'bz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 16'h0000;
      th  <= 8'h00;
      tl  <= 8'h00;
    end else begin
      cnt <= tick ? {th, tl} : cnt + 16'd1;
      if (we_th) th <= DB;
      if (we_tl) tl <= DB;
    end
  end

  // Mode 0: one engine serves both directions, TxD low/high one tick each
  assign m0_tx_go = we_sbuf && (sm == 2'd0) && (m0_st == M0_IDLE) && !tx_busy;
  assign m0_rx_go = !m0_tx_go && (sm == 2'd0) && scon[4] && !scon[0]
                    && (m0_st == M0_IDLE);
  assign m0_last  = (m0_cnt == 4'd8);
  assign m0_done  = (m0_st == M0_HIGH) && tick && m0_last;

  always_ff @(posedge clk) begin
    if (!rst_n) m0_st <= M0_IDLE;
    else        m0_st <= m0_nx;
  end

  always_comb begin
    m0_nx = m0_st;
    unique case (m0_st)
      M0_IDLE: if (m0_tx_go || m0_rx_go) m0_nx = M0_WAIT;
      M0_WAIT: if (tick) m0_nx = M0_LOW;
      M0_LOW:  if (tick) m0_nx = M0_HIGH;
      M0_HIGH: if (tick) m0_nx = m0_last ? M0_IDLE : M0_LOW;
      default: m0_nx = M0_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m0_rx  <= 1'b0;
      m0_sh  <= 8'h00;
      m0_cnt <= 4'd0;
    end else if (m0_tx_go) begin
      m0_rx  <= 1'b0;
      m0_sh  <= DB;
      m0_cnt <= 4'd0;
    end else if (m0_rx_go) begin
      m0_rx  <= 1'b1;
      m0_cnt <= 4'd0;
    end else if (tick) begin
      if (m0_st == M0_LOW) begin
        m0_cnt <= m0_cnt + 4'd1;
        if (m0_rx) m0_sh <= {rxd_in, m0_sh[7:1]};
      end
      if (m0_st == M0_HIGH && !m0_rx && !m0_last)
        m0_sh <= {1'b0, m0_sh[7:1]};
    end
  end

  assign RxD = (m0_st != M0_IDLE && !m0_rx) ? m0_sh[0] : 1'bz;
  assign TxD = (m0_st == M0_LOW) ? 1'b0 : (tx_busy ? tx_sh[0] : 1'b1);

  assign tx_go   = we_sbuf && (sm != 2'd0) && !tx_busy && (m0_st == M0_IDLE);
  assign tx_done = tx_busy && tick && (tx_tc == 4'd15) && (tx_bc == tx_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_busy <= 1'b0;
      tx_sh   <= 11'h000;
      tx_tc   <= 4'd0;
      tx_bc   <= 4'd0;
      tx_last <= 4'd0;
    end else if (tx_go) begin
      tx_busy <= 1'b1;
      tx_sh   <= (sm == 2'd1) ? {2'b11, DB, 1'b0} : {1'b1, scon[3], DB, 1'b0};
      tx_last <= (sm == 2'd1) ? 4'd9 : 4'd10;
      tx_tc   <= 4'd0;
      tx_bc   <= 4'd0;
    end else if (tx_busy && tick) begin
      tx_tc <= tx_tc + 4'd1;
      if (tx_tc == 4'd15) begin
        tx_sh <= {1'b1, tx_sh[10:1]};
        tx_bc <= tx_bc + 4'd1;
        if (tx_bc == tx_last) tx_busy <= 1'b0;
      end
    end
  end

  // Bit decided at tick 9 so the tick 7/8/9 vote is available
`ifdef UART_RX_MAJORITY_EN
  assign rx_bit = (rx_s0 & rx_s1) | (rx_s0 & rxd_in) | (rx_s1 & rxd_in);
`else
  assign rx_bit = rx_s1;
`endif

  assign rx_go     = !rx_busy && scon[4] && (sm != 2'd0) && rx_prev && !rxd_in
                     && (m0_st == M0_IDLE);
  assign rx_eval   = rx_busy && tick && (rx_tc == 4'd8);
  assign rx_fin    = rx_eval && (rx_m1 ? (rx_bc == 4'd9) : (rx_bc == 4'd10));
  assign rx_nine   = rx_m1 ? rx_bit : rx_b9;
  assign rx_accept = rx_fin && !scon[0] && (!scon[5] || rx_nine);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_busy <= 1'b0;
      rx_prev <= 1'b1;
      rx_m1   <= 1'b0;
      rx_b9   <= 1'b0;
      rx_s1   <= 1'b0;
      rx_tc   <= 4'd0;
      rx_bc   <= 4'd0;
      rx_data <= 8'h00;
`ifdef UART_RX_MAJORITY_EN
      rx_s0   <= 1'b0;
`endif
    end else begin
      rx_prev <= rxd_in;
      if (rx_go) begin
        rx_busy <= 1'b1;
        rx_m1   <= (sm == 2'd1);
        rx_tc   <= 4'd0;
        rx_bc   <= 4'd0;
      end else if (rx_busy && tick) begin
        rx_tc <= rx_tc + 4'd1;
`ifdef UART_RX_MAJORITY_EN
        if (rx_tc == 4'd6) rx_s0 <= rxd_in;
`endif
        if (rx_tc == 4'd7)  rx_s1 <= rxd_in;
        if (rx_tc == 4'd15) rx_bc <= rx_bc + 4'd1;
        if (rx_eval) begin
          if (rx_bc == 4'd0 && rx_bit) rx_busy <= 1'b0;
          if (rx_bc >= 4'd1 && rx_bc <= 4'd8)
            rx_data <= {rx_bit, rx_data[7:1]};
          if (rx_bc == 4'd9) rx_b9 <= rx_bit;
          if (rx_fin) rx_busy <= 1'b0;
        end
      end
    end
  end

  // Hardware TI/RI set wins over a simultaneous software write
  always_comb begin
    scon_nx = scon;
    if (rx_accept) scon_nx[2] = rx_nine;
    if (we_scon) scon_nx = DB;
    if (tx_done || (m0_done && !m0_rx)) scon_nx[1] = 1'b1;
    if (rx_accept || (m0_done && m0_rx)) scon_nx[0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scon    <= 8'h00;
      rx_sbuf <= 8'h00;
    end else begin
      scon <= scon_nx;
      if (m0_done && m0_rx) rx_sbuf <= m0_sh;
      else if (rx_accept)   rx_sbuf <= rx_data;
    end
  end

endmodule

// File: tb/tb_uart.sv
// Directed bench for uart: mode 0 tx/rx, async loopback, discard cases, reset.
module tb_uart;

  localparam logic [7:0] A_TL   = 8'h96;
  localparam logic [7:0] A_TH   = 8'h97;
  localparam logic [7:0] A_SBUF = 8'h98;
  localparam logic [7:0] A_SCON = 8'h99;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] AB = 8'h00;
  logic       rd = 1'b1;
  logic       wr = 1'b1;
  logic       db_en = 1'b0;
  logic [7:0] db_val = 8'h00;
  logic       rx_en = 1'b1;
  logic       rx_val = 1'b1;
  logic       lb = 1'b0;
  logic [8:0] dly = 9'h1FF;
  wire  [7:0] DB;
  wire        RxD;
  wire        TxD;
  wire        Intuart;

  int n_checks = 0;
  int n_errors = 0;

  assign DB  = db_en ? db_val : 8'bz;
  assign RxD = rx_en ? (lb ? dly[8] : rx_val) : 1'bz;

  always #5 clk = ~clk;
  always @(posedge clk) dly <= {dly[7:0], TxD};

  uart dut (
    .clk(clk), .rst_n(rst_n), .AB(AB), .DB(DB), .rd(rd), .wr(wr),
    .TxD(TxD), .RxD(RxD), .Intuart(Intuart)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    AB = a; db_val = d; db_en = 1'b1; wr = 1'b0;
    @(negedge clk);
    wr = 1'b1; db_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    AB = a; rd = 1'b0;
    #2 d = DB;
    rd = 1'b1;
  endtask

  task automatic wait_scon(input string tag, input logic [7:0] mask,
                           input int budget);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < budget; i++) begin
      bus_rd(A_SCON, v);
      if ((v & mask) == mask) break;
    end
    check(tag, v & mask, mask);
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a,
                          input logic [7:0] exp);
    logic [7:0] v;
    bus_rd(a, v);
    check(tag, v, exp);
  endtask

  initial begin
    logic [7:0] cap;
    logic [7:0] data;
    logic       prev;
    int         n;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_txd", TxD, 1'b1);
    check("rst_int", Intuart, 1'b0);
    rd_check("rst_scon", A_SCON, 8'h00);
    rd_check("rst_sbuf", A_SBUF, 8'h00);
    rd_check("rst_th", A_TH, 8'h00);
    rd_check("rst_tl", A_TL, 8'h00);

    bus_wr(A_TH, 8'hFF);
    bus_wr(A_TL, 8'hFD);
    rd_check("th_rd", A_TH, 8'hFF);
    rd_check("tl_rd", A_TL, 8'hFD);
    repeat (65600) @(negedge clk);

    // mode 0 transmit, bench samples RxD on each TxD rise
    rx_en = 1'b0;
    bus_wr(A_SCON, 8'h08);
    bus_wr(A_SBUF, 8'hA9);
    cap = 8'h00; n = 0; prev = TxD;
    for (int i = 0; i < 400 && n < 8; i++) begin
      @(negedge clk);
      if (!prev && TxD) begin
        cap = {RxD, cap[7:1]};
        n++;
      end
      prev = TxD;
    end
    check("m0tx_edges", n, 8);
    check("m0tx_data", cap, 8'hA9);
    wait_scon("m0tx_ti", 8'h02, 100);
    check("m0tx_int", Intuart, 1'b1);
    check("m0tx_txd", TxD, 1'b1);
    rd_check("m0tx_scon", A_SCON, 8'h0A);
    bus_wr(A_SCON, 8'h08);
    check("m0tx_intclr", Intuart, 1'b0);

    // mode 0 receive, bench changes data after each TxD rise
    data = 8'hA9;
    rx_val = data[0];
    rx_en = 1'b1;
    bus_wr(A_SCON, 8'h18);
    n = 0; prev = TxD;
    for (int i = 0; i < 400 && n < 8; i++) begin
      @(negedge clk);
      if (!prev && TxD) begin
        n++;
        if (n < 8) rx_val = data[n];
      end
      prev = TxD;
    end
    check("m0rx_edges", n, 8);
    wait_scon("m0rx_ri", 8'h01, 100);
    rd_check("m0rx_scon", A_SCON, 8'h19);
    rd_check("m0rx_sbuf", A_SBUF, 8'hA9);

    // mode 1 loopback
    rx_val = 1'b1;
    lb = 1'b1;
    bus_wr(A_SCON, 8'h48);
    bus_wr(A_SBUF, 8'hA9);
    bus_wr(A_SCON, 8'h58);
    wait_scon("m1_ti_ri", 8'h03, 1500);
    rd_check("m1_scon", A_SCON, 8'h5F);
    rd_check("m1_sbuf", A_SBUF, 8'hA9);

    // mode 2 loopback, TB8=1
    bus_wr(A_SCON, 8'h88);
    bus_wr(A_SBUF, 8'hA9);
    bus_wr(A_SCON, 8'h98);
    wait_scon("m2_ti_ri", 8'h03, 1500);
    rd_check("m2_scon", A_SCON, 8'h9F);
    rd_check("m2_sbuf", A_SBUF, 8'hA9);

    // mode 3 loopback, TB8=0 and SM2=0 still accepted
    bus_wr(A_SCON, 8'hC0);
    bus_wr(A_SBUF, 8'h5C);
    bus_wr(A_SCON, 8'hD0);
    wait_scon("m3_ti_ri", 8'h03, 1500);
    rd_check("m3_scon", A_SCON, 8'hD3);
    rd_check("m3_sbuf", A_SBUF, 8'h5C);

    // mode 2 with SM2=1 and 9th bit 0: frame discarded
    bus_wr(A_SCON, 8'hA0);
    bus_wr(A_SBUF, 8'h33);
    bus_wr(A_SCON, 8'hB0);
    wait_scon("sm2_ti", 8'h02, 1500);
    repeat (200) @(negedge clk);
    rd_check("sm2_scon", A_SCON, 8'hB2);
    rd_check("sm2_sbuf", A_SBUF, 8'h5C);

    // mode 1 frame while RI already set: discarded
    bus_wr(A_SCON, 8'h41);
    bus_wr(A_SBUF, 8'h77);
    bus_wr(A_SCON, 8'h51);
    wait_scon("ri1_ti", 8'h02, 1500);
    repeat (200) @(negedge clk);
    rd_check("ri1_scon", A_SCON, 8'h53);
    rd_check("ri1_sbuf", A_SBUF, 8'h5C);

    // short low glitch on RxD (4 ticks)
    lb = 1'b0;
    rx_val = 1'b1;
    bus_wr(A_SCON, 8'h50);
    repeat (5) @(negedge clk);
    rx_val = 1'b0;
    repeat (12) @(negedge clk);
    rx_val = 1'b1;
    repeat (700) @(negedge clk);
    rd_check("glitch_scon", A_SCON, 8'h50);
    rd_check("glitch_sbuf", A_SBUF, 8'h5C);

    // reset in the middle of a mode 1 frame
    bus_wr(A_SCON, 8'h41);
    bus_wr(A_SBUF, 8'h00);
    repeat (100) @(negedge clk);
    check("pre_rst_txd", TxD, 1'b0);
    check("pre_rst_int", Intuart, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_txd", TxD, 1'b1);
    check("mid_rst_int", Intuart, 1'b0);
    rd_check("mid_rst_scon", A_SCON, 8'h00);
    rd_check("mid_rst_sbuf", A_SBUF, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart.md
Name: uart

Overview:
- 8051-style serial port with a byte-wide memory-mapped bus interface.
- Four modes:
  - Mode 0: synchronous shift register; TxD is the shift clock, RxD is bidirectional data.
  - Mode 1: 10-bit asynchronous frame.
  - Modes 2/3: 11-bit asynchronous frame with 9th bit.
- A 16-bit auto-reload baud timer drives every mode.
- Intuart flags TX/RX completion to the CPU.

Parameters:
- none (register addresses fixed: TL 0x96, TH 0x97, SBUF 0x98, SCON 0x99)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- AB  in  8  register address
- DB  inout  8  data bus; driven only during decoded reads, else high-Z
- rd  in  1  active-low read strobe
- wr  in  1  active-low write strobe
- TxD  out  1  serial out (modes 1-3) / shift clock (mode 0)
- RxD  inout  1  serial in (modes 1-3) / shift data (mode 0), high-Z unless transmitting in mode 0
- Intuart  out  1  interrupt = TI | RI

Behaviour:
- Reset values: SCON=0, TH=TL=0, timer counter=0, RX SBUF=0, TX buffer=0, TxD=1, RxD=Z, DB=Z, Intuart=0; all state machines idle.
- Bus write: on a clk edge with wr=0, write DB to the register at AB. Unmapped addresses are ignored.
- Bus read: while rd=0 and AB matches a register, DB drives it combinationally:
  - SCON.
  - RX SBUF.
  - TH/TL reload values.
- SCON bits: [7:6] SM, [5] SM2, [4] REN, [3] TB8, [2] RB8, [1] TI, [0] RI.
  - All bits are software-writable; TI/RI are cleared only by software.
  - If hardware sets TI/RI in the same cycle as an SCON write, the hardware set wins for that bit; other bits take the written value.
- Baud timer: 16-bit counter increments every clk. On 0xFFFF it reloads {TH,TL} and emits a 1-cycle tick. Writing TH/TL does not disturb the running count.
- Mode 0 transmit:
  - Writing SBUF starts the shift; RxD is driven LSB first.
  - TxD idles high, goes low for one tick period (data changes on the falling transition), then high for one tick period.
  - 8 rising TxD edges, then TI=1, RxD released to Z, TxD=1.
- Mode 0 receive:
  - Starts when REN=1 and RI=0 in mode 0.
  - Generates 8 TxD clocks with the same timing as transmit.
  - Samples RxD, LSB first, on the clk edge that raises TxD; the external device updates data after that rising edge.
  - After the 8th bit: SBUF loaded, RI=1.
- Modes 1/2/3 bit time: 16 ticks. Mode 2 uses the timer identically to mode 3.
- Async transmit:
  - Writing SBUF sends start(0), D0..D7, then [TB8 in modes 2/3], then stop(1).
  - TI=1 at the end of the stop bit; TxD idles 1.
- Async receive:
  - Enabled by REN=1. A falling edge on RxD arms the receiver; 16x oversampled, with the sample at tick 8 of each bit.
  - Start bit sampled 1 → abort, return to idle.
  - Mode 1: RB8 = stop bit.
  - Modes 2/3: RB8 = 9th bit.
  - At the end of the frame, load SBUF/RB8 and set RI only if RI=0, and:
    - SM2=0, or
    - mode 1 with stop=1, or
    - modes 2/3 with 9th bit=1.
  - Otherwise discard the frame.
- TX and RX are independent and may run simultaneously in modes 1-3.
- An SBUF write while transmission is active is ignored.
- Changing SM mid-frame: the current frame completes in the old mode.
- Reset asserted mid-frame aborts everything to the reset values at the next clk edge.

Optional Feature:
- UART_RX_MAJORITY_EN
- Defined: async receive takes a 2-of-3 majority of samples at ticks 7, 8, 9 of each bit (including start-bit validation).
- Undefined: single sample at tick 8.

Test Plan:
- Mode 0 TX: TH=0xFF, TL=0xFD, SCON=0x08, SBUF=0xA9 → bits captured on RxD at 8 TxD rising edges, LSB first, = 0xA9; then TI=1, Intuart=1. Write SCON with TI cleared → Intuart=0.
- Mode 0 RX: SCON=0x18; external device presents 0xA9 bits LSB first, changing after each TxD rise → RI=1, SBUF read = 0xA9.
- Mode 1 loopback (TxD→RxD, 9-clk delay): SCON=0x48, SBUF=0xA9, then SCON=0x58 → TI then RI set, SBUF=0xA9, RB8=1 (stop bit).
- Mode 2 loopback: SCON=0x88, SBUF=0xA9, then SCON=0x98 → SBUF=0xA9, RB8=1. Repeat with TB8=0 and SM2=1 → RI stays 0.
- Corner cases:
  - Glitch low on RxD shorter than 8 ticks → no reception.
  - Reset pulse mid-frame → TxD=1, SCON=0, Intuart=0.
  - Second frame arriving while RI=1 → discarded, SBUF unchanged.
